// File: rtl/byte_lane_unpacker16.sv
// Byte-lane unpacker: splits a 16-bit word into its enabled bytes on an 8-bit stream.
// Optional out_parity port when BYTE_LANE_UNPACKER_PARITY_EN is defined.
module byte_lane_unpacker16 #(
    parameter int MSB_FIRST = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic [1:0]       in_ena,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_lane,
    output logic             out_last,
    output logic [CNT_W-1:0] drop_cnt
`ifdef BYTE_LANE_UNPACKER_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [15:0]      r_word, w_word_nxt;
    logic [1:0]       r_mask, w_mask_nxt;
    logic             r_valid, w_valid_nxt;
    logic [7:0]       r_data, w_data_nxt;
    logic             r_lane, w_lane_nxt;
    logic             r_last, w_last_nxt;
    logic [CNT_W-1:0] r_drop;
    logic             w_drop_inc;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_msb_first;
    logic [1:0]       w_rest_mask;

    function automatic logic [7:0] lane_byte(
        input logic [15:0] word,
        input logic        lane
    );
        return lane ? word[15:8] : word[7:0];
    endfunction

    assign w_msb_first = (MSB_FIRST != 0);
    // r_mask tracks the lane still owed after the first byte of a two-lane word
    assign w_rest_mask = w_msb_first ? 2'b01 : 2'b10;

    assign in_ready   = (r_state == IDLE);
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = r_valid & out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_mask_nxt  = r_mask;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_lane_nxt  = r_lane;
        w_last_nxt  = r_last;
        w_drop_inc  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_in_xfer) begin
                    w_word_nxt = in_data;
                    unique case (1'b1)
                        (in_ena == 2'b11): begin
                            w_state_nxt = FIRST;
                            w_mask_nxt  = w_rest_mask;
                            w_valid_nxt = 1'b1;
                            w_lane_nxt  = w_msb_first;
                            w_data_nxt  = lane_byte(in_data, w_msb_first);
                            w_last_nxt  = 1'b0;
                        end
                        (in_ena == 2'b01),
                        (in_ena == 2'b10): begin
                            w_state_nxt = SECOND;
                            w_mask_nxt  = 2'b00;
                            w_valid_nxt = 1'b1;
                            w_lane_nxt  = in_ena[1];
                            w_data_nxt  = lane_byte(in_data, in_ena[1]);
                            w_last_nxt  = 1'b1;
                        end
                        default: begin
                            w_mask_nxt = 2'b00;
                            w_drop_inc = 1'b1;
                        end
                    endcase
                end
            end
            FIRST: begin
                if (w_out_xfer) begin
                    w_state_nxt = SECOND;
                    w_mask_nxt  = 2'b00;
                    w_lane_nxt  = r_mask[1];
                    w_data_nxt  = lane_byte(r_word, r_mask[1]);
                    w_last_nxt  = 1'b1;
                end
            end
            SECOND: begin
                if (w_out_xfer) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_word  <= 16'h0000;
            r_mask  <= 2'b00;
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_lane  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_mask  <= w_mask_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_lane  <= w_lane_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Saturates at all-ones; only reset clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop <= '0;
        end else if (w_drop_inc && (r_drop != {CNT_W{1'b1}})) begin
            r_drop <= r_drop + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_lane  = r_lane;
    assign out_last  = r_last;
    assign drop_cnt  = r_drop;

`ifdef BYTE_LANE_UNPACKER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_data_nxt;
        end
    end

    assign out_parity = r_parity;
`endif

endmodule

// File: tb/tb_byte_lane_unpacker16.sv
// Directed bench for byte_lane_unpacker16: lane order, single lanes,
// backpressure, drop counter saturation and asynchronous reset.
module tb_byte_lane_unpacker16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_ena;
    logic        out_ready;

    logic       rdy0, vld0, lane0, last0;
    logic [7:0] data0, cnt0;
    logic       rdy1, vld1, lane1, last1;
    logic [7:0] data1, cnt1;
    logic       rdy2, vld2, lane2, last2;
    logic [7:0] data2;
    logic [1:0] cnt2;
`ifdef BYTE_LANE_UNPACKER_PARITY_EN
    logic par0, par1, par2;
`endif

    int n_chk;
    int n_pass;

    byte_lane_unpacker16 #(.MSB_FIRST(0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_ena(in_ena),
        .out_valid(vld0), .out_ready(out_ready),
        .out_data(data0), .out_lane(lane0), .out_last(last0),
        .drop_cnt(cnt0)
`ifdef BYTE_LANE_UNPACKER_PARITY_EN
        , .out_parity(par0)
`endif
    );

    byte_lane_unpacker16 #(.MSB_FIRST(1), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_ena(in_ena),
        .out_valid(vld1), .out_ready(out_ready),
        .out_data(data1), .out_lane(lane1), .out_last(last1),
        .drop_cnt(cnt1)
`ifdef BYTE_LANE_UNPACKER_PARITY_EN
        , .out_parity(par1)
`endif
    );

    byte_lane_unpacker16 #(.MSB_FIRST(0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data), .in_ena(in_ena),
        .out_valid(vld2), .out_ready(out_ready),
        .out_data(data2), .out_lane(lane2), .out_last(last2),
        .drop_cnt(cnt2)
`ifdef BYTE_LANE_UNPACKER_PARITY_EN
        , .out_parity(par2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive one word before a posedge; returns on the following negedge
    task automatic send(input logic [15:0] d, input logic [1:0] e);
        in_valid = 1'b1;
        in_data  = d;
        in_ena   = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic byte0(input string tag, input logic [7:0] d,
                         input logic l, input logic la);
        chk({tag, "_vld"}, 32'(vld0), 32'd1);
        chk({tag, "_dat"}, 32'(data0), 32'(d));
        chk({tag, "_lane"}, 32'(lane0), 32'(l));
        chk({tag, "_last"}, 32'(last0), 32'(la));
    endtask

    task automatic byte1(input string tag, input logic [7:0] d,
                         input logic l, input logic la);
        chk({tag, "_vld"}, 32'(vld1), 32'd1);
        chk({tag, "_dat"}, 32'(data1), 32'(d));
        chk({tag, "_lane"}, 32'(lane1), 32'(l));
        chk({tag, "_last"}, 32'(last1), 32'(la));
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hA55A;
        in_ena    = 2'b11;
        out_ready = 1'b1;
        #1 reset  = 1'b0;

        // reset state, inputs already presenting a word
        @(negedge clk);
        chk("rst_vld", 32'(vld0), 32'd0);
        chk("rst_rdy", 32'(rdy0), 32'd1);
        chk("rst_dat", 32'(data0), 32'h0);
        chk("rst_lane", 32'(lane0), 32'd0);
        chk("rst_last", 32'(last0), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        byte0("a55a_b0", 8'h5A, 1'b0, 1'b0);
        chk("a55a_rdy0", 32'(rdy0), 32'd0);
        step();
        byte0("a55a_b1", 8'hA5, 1'b1, 1'b1);
        chk("a55a_rdy1", 32'(rdy0), 32'd0);
        step();
        chk("a55a_end", 32'(vld0), 32'd0);
        chk("a55a_idle", 32'(rdy0), 32'd1);

        // MSB_FIRST ordering
        send(16'h1234, 2'b11);
        byte1("msb_b0", 8'h12, 1'b1, 1'b0);
        byte0("lsb_b0", 8'h34, 1'b0, 1'b0);
        step();
        byte1("msb_b1", 8'h34, 1'b0, 1'b1);
        byte0("lsb_b1", 8'h12, 1'b1, 1'b1);
        step();
        chk("msb_end", 32'(vld1), 32'd0);

        // single lanes
        send(16'hBEEF, 2'b10);
        byte0("hi_only", 8'hBE, 1'b1, 1'b1);
        byte1("hi_only1", 8'hBE, 1'b1, 1'b1);
        step();
        chk("hi_end", 32'(vld0), 32'd0);
        send(16'hBEEF, 2'b01);
        byte0("lo_only", 8'hEF, 1'b0, 1'b1);
        step();
        chk("lo_end", 32'(vld0), 32'd0);

        // backpressure on the first byte
        out_ready = 1'b0;
        send(16'hC381, 2'b11);
        byte0("bp_first", 8'h81, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            byte0("bp_hold", 8'h81, 1'b0, 1'b0);
            chk("bp_rdy", 32'(rdy0), 32'd0);
        end
        out_ready = 1'b1;
        step();
        byte0("bp_b1", 8'hC3, 1'b1, 1'b1);
        step();
        chk("bp_end", 32'(vld0), 32'd0);

        // dropped words
        for (int i = 0; i < 3; i++) begin
            send(16'h5555, 2'b00);
            chk("drop_novld", 32'(vld0), 32'd0);
            chk("drop_rdy", 32'(rdy0), 32'd1);
        end
        chk("drop_cnt3", 32'(cnt0), 32'd3);
        chk("drop_cnt3_w2", 32'(cnt2), 32'd3);
        send(16'h5555, 2'b00);
        send(16'h5555, 2'b00);
        chk("drop_cnt5", 32'(cnt0), 32'd5);
        chk("drop_sat_w2", 32'(cnt2), 32'd3);

`ifdef BYTE_LANE_UNPACKER_PARITY_EN
        send(16'h0307, 2'b11);
        chk("par_07_dat", 32'(data0), 32'h07);
        chk("par_07", 32'(par0), 32'd1);
        step();
        chk("par_03_dat", 32'(data0), 32'h03);
        chk("par_03", 32'(par0), 32'd0);
        step();
`endif

        // asynchronous reset mid-word
        out_ready = 1'b0;
        send(16'hA55A, 2'b11);
        byte0("ar_pre", 8'h5A, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("ar_vld", 32'(vld0), 32'd0);
        chk("ar_rdy", 32'(rdy0), 32'd1);
        chk("ar_cnt", 32'(cnt0), 32'd0);
        chk("ar_cnt_w2", 32'(cnt2), 32'd0);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        step();
        chk("ar_post_vld", 32'(vld0), 32'd0);
        chk("ar_post_rdy", 32'(rdy0), 32'd1);
        step();
        chk("ar_no_stale", 32'(vld0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
